// File: rtl/sobel_window_gen_pkg.sv
// Shared types and defaults for the Sobel 3x3 window generator.
package sobel_pkg;

    localparam int IMG_WIDTH_DEFAULT  = 352;
    localparam int IMG_HEIGHT_DEFAULT = 288;

    typedef logic [7:0] pixel_t;

    // Nine-pixel neighbourhood, s{row}{col}; s11 is top-left, s22 the centre.
    typedef struct packed {
        pixel_t s11; pixel_t s12; pixel_t s13;
        pixel_t s21; pixel_t s22; pixel_t s23;
        pixel_t s31; pixel_t s32; pixel_t s33;
    } window_t;

    // One vertical slice of the window, top to bottom.
    typedef struct packed {
        pixel_t top;
        pixel_t mid;
        pixel_t bot;
    } column_t;

    // Drop the leftmost column and append a new rightmost column.
    function automatic window_t shift_window(window_t w, column_t c);
        window_t r;
        r.s11 = w.s12; r.s12 = w.s13; r.s13 = c.top;
        r.s21 = w.s22; r.s22 = w.s23; r.s23 = c.mid;
        r.s31 = w.s32; r.s32 = w.s33; r.s33 = c.bot;
        return r;
    endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out handshake bundle of the Sobel window generator.
interface sobel_window_gen_if;
    import sobel_pkg::*;

    logic   in_valid;
    logic   in_ready;
    pixel_t in_pixel;
    logic   out_valid;
    logic   out_ready;
    pixel_t s11, s12, s13;
    pixel_t s21, s22, s23;
    pixel_t s31, s32, s33;
    logic   out_last;
    logic   frame_done;

    // Block side: consumes pixels, produces windows.
    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid,
        output s11, s12, s13, s21, s22, s23, s31, s32, s33,
        output out_last, frame_done
    );

    // Environment side: pixel source and window sink.
    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid,
        input  s11, s12, s13, s21, s22, s23, s31, s32, s33,
        input  out_last, frame_done
    );

endinterface

// File: rtl/sobel_window_gen_line_buffer.sv
// One image row of pixels: asynchronous read, synchronous write, no reset.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = IMG_WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  pixel_t                   wdata,
    output pixel_t                   rdata
);

    pixel_t mem [DEPTH];

    // Write the accepted pixel's column slot; contents refill every frame.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator feeding the Sobel kernel.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEFAULT,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    sobel_window_gen_if.slave bus
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0] col_p0;
    logic [RW-1:0] row_p0;
    logic          accept;
    logic          col_last;
    logic          row_last;
    logic          emit;
    pixel_t        lb0_rd;
    pixel_t        lb1_rd;
    column_t       new_col;

    window_t       win_p1;
    logic          vld_p1;
    logic          last_p1;
    logic          frame_done_p1;

    // A full output register frees the input only when it is being drained.
    assign bus.in_ready = !vld_p1 || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign col_last = (col_p0 == CW'(IMG_WIDTH - 1));
    assign row_last = (row_p0 == RW'(IMG_HEIGHT - 1));
    // Columns 0..1 and rows 0..1 hold stale or missing neighbours.
    assign emit     = (row_p0 >= RW'(2)) && (col_p0 >= CW'(2));

    // lb0 holds row r-1; lb1 holds row r-2; both indexed by column.
    sobel_line_buffer #(.DEPTH(IMG_WIDTH)) lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_p0),
        .wdata (bus.in_pixel),
        .rdata (lb0_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH)) lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_p0),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    assign new_col.top = lb1_rd;
    assign new_col.mid = lb0_rd;
    assign new_col.bot = bus.in_pixel;

    // ---- stage p0: raster position of the next pixel to accept ----
    // Column/row counters advance only on accepted pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_p0 <= '0;
            row_p0 <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_p0 <= '0;
                row_p0 <= row_last ? '0 : row_p0 + RW'(1);
            end else begin
                col_p0 <= col_p0 + CW'(1);
            end
        end
    end

    // ---- stage p1: window register presented to the kernel ----
    // Shift the window left by one column on every accepted pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_p1 <= '0;
        end else if (accept) begin
            win_p1 <= shift_window(win_p1, new_col);
        end
    end

    // Output valid/last hold under backpressure; frame_done ignores out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1        <= 1'b0;
            last_p1       <= 1'b0;
            frame_done_p1 <= 1'b0;
        end else begin
            frame_done_p1 <= accept && col_last && row_last;
            if (accept) begin
                vld_p1  <= emit;
                last_p1 <= emit && col_last && row_last;
            end else if (bus.out_ready) begin
                vld_p1  <= 1'b0;
                last_p1 <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = vld_p1;
    assign bus.out_last   = last_p1;
    assign bus.frame_done = frame_done_p1;
    assign bus.s11 = win_p1.s11;
    assign bus.s12 = win_p1.s12;
    assign bus.s13 = win_p1.s13;
    assign bus.s21 = win_p1.s21;
    assign bus.s22 = win_p1.s22;
    assign bus.s23 = win_p1.s23;
    assign bus.s31 = win_p1.s31;
    assign bus.s32 = win_p1.s32;
    assign bus.s33 = win_p1.s33;

endmodule
